// File: rtl/login_pkg.sv
// Shared types and widths for the login controller slice.
package login_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_RESP   = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    localparam int unsigned CRED_W = 64;
    localparam int unsigned CNT_W  = 16;

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter for the lockout window; holds at zero once expired.
module lockout_timer
    import login_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         expired
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/login_controller.sv
// Request/response front end for the credential verifier with failure lockout.
// Optional audit counters are built only when LOGIN_AUDIT_COUNTERS_EN is defined.
module login_controller
    import login_pkg::*;
#(
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CRED_W-1:0] req_username,
    input  logic [CRED_W-1:0] req_password,
    output logic [CRED_W-1:0] ver_username,
    output logic [CRED_W-1:0] ver_password,
    input  logic              ver_valid,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_granted,
    output logic              resp_lockout,
    output logic              locked,
    output logic [CNT_W-1:0]  grant_count,
    output logic [CNT_W-1:0]  deny_count
);

    localparam logic [3:0]       MAX_F     = 4'(MAX_FAILS);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);

    state_t           state, state_next;
    logic [3:0]       fail_cnt, fail_cnt_next;
    logic             timer_load, timer_expired;
    logic [CNT_W-1:0] lock_timer;

    lockout_timer #(.W(CNT_W)) u_lockout_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (LOCK_LOAD),
        .count      (lock_timer),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        locked     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = S_CHECK;
            end
            S_CHECK: state_next = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    timer_load = resp_lockout;
                    state_next = resp_lockout ? S_LOCKED : S_IDLE;
                end
            end
            S_LOCKED: begin
                locked = 1'b1;
                if (timer_expired) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Saturating failure count; a grant clears the streak.
    always_comb begin
        if (ver_valid)              fail_cnt_next = '0;
        else if (fail_cnt >= MAX_F) fail_cnt_next = MAX_F;
        else                        fail_cnt_next = fail_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ver_username <= '0;
            ver_password <= '0;
            fail_cnt     <= '0;
            resp_granted <= 1'b0;
            resp_lockout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    ver_username <= req_username;
                    ver_password <= req_password;
                end
                S_CHECK: begin
                    fail_cnt     <= fail_cnt_next;
                    resp_granted <= ver_valid;
                    resp_lockout <= !ver_valid && (fail_cnt_next == MAX_F);
                end
                S_LOCKED: if (timer_expired) fail_cnt <= '0;
                default: ;
            endcase
        end
    end

`ifdef LOGIN_AUDIT_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count <= '0;
            deny_count  <= '0;
        end else if (state == S_CHECK) begin
            if (ver_valid && grant_count != '1)  grant_count <= grant_count + 1'b1;
            if (!ver_valid && deny_count != '1)  deny_count  <= deny_count + 1'b1;
        end
    end
`else
    assign grant_count = '0;
    assign deny_count  = '0;
`endif

    timer_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        lock_timer <= LOCK_LOAD);

endmodule

// File: tb/tb_login_controller.sv
// Directed bench for login_controller; expectations honour LOGIN_AUDIT_COUNTERS_EN.
module tb_login_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_username, req_password;
    logic [63:0] ver_username, ver_password;
    logic        ver_valid;
    logic        resp_valid, resp_ready, resp_granted, resp_lockout, locked;
    logic [15:0] grant_count, deny_count;

    localparam logic [63:0] GOOD_U = "alice";
    localparam logic [63:0] GOOD_P = "s3cret!";
    localparam logic [63:0] BAD_P  = "guess";
    localparam logic [63:0] OTHER  = "mallory";

    int compared   = 0;
    int mismatched = 0;
    int gc_model   = 0;
    int dc_model   = 0;

    login_controller #(.MAX_FAILS(3), .LOCK_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_username (req_username),
        .req_password (req_password),
        .ver_username (ver_username),
        .ver_password (ver_password),
        .ver_valid    (ver_valid),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_granted (resp_granted),
        .resp_lockout (resp_lockout),
        .locked       (locked),
        .grant_count  (grant_count),
        .deny_count   (deny_count)
    );

    // Stand-in for the combinational verifier: one valid credential pair.
    assign ver_valid = (ver_username == GOOD_U) && (ver_password == GOOD_P);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] audit(input int n);
`ifdef LOGIN_AUDIT_COUNTERS_EN
        return 64'(n);
`else
        return 64'(n - n);
`endif
    endfunction

    task automatic transact(input logic [63:0] u, input logic [63:0] p,
                            input logic exp_g, input logic exp_l);
        @(negedge clk);
        check("idle_ready", req_ready, 1);
        req_valid = 1'b1; req_username = u; req_password = p;
        @(negedge clk);
        req_valid = 1'b0;
        check("check_ready", req_ready, 0);
        check("check_rv", resp_valid, 0);
        check("ver_user", ver_username, u);
        check("ver_pass", ver_password, p);
        if (exp_g) gc_model++; else dc_model++;
        @(negedge clk);
        check("resp_valid", resp_valid, 1);
        check("resp_granted", resp_granted, exp_g);
        check("resp_lockout", resp_lockout, exp_l);
        check("grant_count", grant_count, audit(gc_model));
        check("deny_count", deny_count, audit(dc_model));
        @(negedge clk);
        if (exp_l) begin
            check("lock_entry", locked, 1);
            check("lock_entry_ready", req_ready, 0);
        end else begin
            check("back_idle", req_ready, 1);
            check("resp_dropped", resp_valid, 0);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        req_username = '0; req_password = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_rv", resp_valid, 0);
        check("rst_granted", resp_granted, 0);
        check("rst_lockout", resp_lockout, 0);
        check("rst_locked", locked, 0);
        check("rst_ver_user", ver_username, 0);
        check("rst_gc", grant_count, 0);
        check("rst_dc", deny_count, 0);
        rst_n = 1'b1;

        transact(GOOD_U, GOOD_P, 1, 0);

        // Three denials in a row trigger a 16-cycle lockout.
        transact(GOOD_U, BAD_P, 0, 0);
        transact(GOOD_U, BAD_P, 0, 0);
        transact(GOOD_U, BAD_P, 0, 1);
        n = 0;
        do begin
            check("lock_ready", req_ready, 0);
            n++;
            req_valid = (n == 5);
            req_username = OTHER;
            @(negedge clk);
        end while (locked && n < 40);
        req_valid = 1'b0;
        check("lock_cycles", 64'(n), 16);
        check("lock_ignored_req", ver_username, GOOD_U);
        check("lock_exit_ready", req_ready, 1);

        // A grant in the middle resets the failure streak.
        transact(GOOD_U, BAD_P, 0, 0);
        transact(GOOD_U, BAD_P, 0, 0);
        transact(GOOD_U, GOOD_P, 1, 0);
        transact(GOOD_U, BAD_P, 0, 0);
        transact(GOOD_U, BAD_P, 0, 0);
        transact(GOOD_U, GOOD_P, 1, 0);

        // Consumer stalls for 10 cycles in RESP.
        @(negedge clk);
        req_valid = 1'b1; req_username = GOOD_U; req_password = GOOD_P;
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b0; gc_model++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_rv", resp_valid, 1);
            check("stall_granted", resp_granted, 1);
            check("stall_ver_user", ver_username, GOOD_U);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("stall_release_rv", resp_valid, 0);
        check("stall_release_ready", req_ready, 1);

        // Reset arrives while LOCKED with the timer at 7.
        transact(GOOD_U, BAD_P, 0, 0);
        transact(GOOD_U, BAD_P, 0, 0);
        transact(GOOD_U, BAD_P, 0, 1);
        repeat (8) @(negedge clk);
        check("pre_reset_locked", locked, 1);
        #2 rst_n = 1'b0;
        #1;
        gc_model = 0; dc_model = 0;
        check("arst_locked", locked, 0);
        check("arst_ready", req_ready, 1);
        check("arst_ver_user", ver_username, 0);
        check("arst_ver_pass", ver_password, 0);
        check("arst_lockout", resp_lockout, 0);
        check("arst_gc", grant_count, 0);
        check("arst_dc", deny_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fail_cnt cleared by reset: one denial must not lock out.
        transact(GOOD_U, BAD_P, 0, 0);
        repeat (5) transact(GOOD_U, GOOD_P, 1, 0);
        transact(OTHER, GOOD_P, 0, 0);
        check("audit_grants", grant_count, audit(5));
        check("audit_denials", deny_count, audit(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/login_controller.md
Name: login_controller

Overview:
Sequential front end for the combinational credential verifier. Accepts one login request at a time over a valid/ready handshake and registers the 64-bit username and password. It drives those registered values to the verifier, samples the verifier's valid result, and returns a grant/deny response over a second valid/ready handshake. It counts consecutive failures and locks out all requests for a fixed number of cycles after MAX_FAILS failures in a row.

Parameters:
MAX_FAILS, 3, consecutive denials that trigger lockout (range 1..15)
LOCK_CYCLES, 16, cycles spent in LOCKED before requests are accepted again (range 1..65535)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_username  input  64  username, packed ASCII, zero-padded
req_password  input  64  password, packed ASCII, zero-padded
ver_username  output  64  registered username driven to the verifier
ver_password  output  64  registered password driven to the verifier
ver_valid  input  1  combinational verifier result
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts the response
resp_granted  output  1  1 = credentials matched
resp_lockout  output  1  1 = this denial triggered lockout
locked  output  1  controller is in LOCKED
grant_count  output  16  audit counter of grants (see Optional Feature)
deny_count  output  16  audit counter of denials (see Optional Feature)

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- FSM states: IDLE, CHECK, RESP, LOCKED. Reset state is IDLE.
- Values forced by reset:
  - ver_username and ver_password: 0
  - fail_cnt and lock_timer: 0
  - resp_valid, resp_granted, resp_lockout and locked: 0
  - grant_count and deny_count: 0
  - req_ready: 1, because the FSM is in IDLE.
- IDLE: req_ready=1. When req_valid && req_ready, capture req_username and req_password into the ver_* registers, then go to CHECK.
- CHECK: req_ready=0. ver_* have been stable for one full cycle; sample ver_valid at the end of this cycle.
  - ver_valid=1 (grant): set resp_granted=1 and clear fail_cnt to 0.
  - ver_valid=0 (deny): set resp_granted=0 and increment fail_cnt, saturating at MAX_FAILS.
  - resp_lockout = (deny && fail_cnt_next == MAX_FAILS).
  - Go to RESP.
- RESP: resp_valid=1. resp_granted and resp_lockout are held stable until resp_valid && resp_ready.
  - On the handshake: clear resp_valid. If resp_lockout is set, go to LOCKED and load lock_timer with LOCK_CYCLES-1; otherwise go to IDLE.
- LOCKED: locked=1 and req_ready=0. lock_timer decrements once per cycle.
  - When lock_timer==0, go to IDLE and clear fail_cnt.
  - Total time in LOCKED is exactly LOCK_CYCLES cycles.
- Latency: request handshake in cycle N gives resp_valid=1 in cycle N+2 (N+1 is CHECK).
- ver_username and ver_password keep the last request's values until the next accepted request; they are not cleared after a response.
- req_ready is a function of state only and does not depend on req_valid.
- req_valid asserted outside IDLE is ignored; no request is buffered.
- Back-to-back operation: a response handshake in cycle M returns the FSM to IDLE in M+1; the earliest next request is accepted in M+1.
- resp_ready held low stalls the FSM in RESP indefinitely with all outputs stable.
- MAX_FAILS=1: every denial sets resp_lockout.
- rst_n asserted mid-operation (any state) immediately forces the reset values; any pending response is discarded.

Optional Feature:
Macro: LOGIN_AUDIT_COUNTERS_EN.
- Defined: grant_count and deny_count are 16-bit saturating counters (stop at 16'hFFFF). A counter increments in the cycle CHECK resolves to grant or deny respectively. Both are cleared only by rst_n.
- Undefined: both ports are tied to 16'h0000 and no counter flops are synthesized.
- The port list is identical in both builds.

Decomposition:
- Shared package login_pkg: state encoding constants S_IDLE=2'd0, S_CHECK=2'd1, S_RESP=2'd2, S_LOCKED=2'd3; CRED_W=64; CNT_W=16.
- One sub-module, lockout_timer:
  - Inputs: load, load_value.
  - Outputs: the count and expired (count==0).
  - Instantiated once for the LOCKED countdown.
- fail_cnt stays inline in the FSM.

Test Plan:
- Valid pair (verifier returns 1), resp_ready=1: req accepted cycle 0 -> resp_valid=1 with resp_granted=1 in cycle 2, resp_lockout=0, back in IDLE cycle 3.
- Three bad passwords, MAX_FAILS=3, LOCK_CYCLES=16 -> third response has resp_granted=0 and resp_lockout=1; locked=1 and req_ready=0 for exactly 16 cycles; a req_valid pulse inside that window is ignored.
- Two denials then one grant, then two denials -> no lockout; fail_cnt is cleared by the grant.
- resp_ready held low for 10 cycles in RESP -> resp_valid, resp_granted and ver_* stable all 10 cycles; FSM goes to IDLE the cycle after resp_ready rises.
- rst_n pulsed low during LOCKED (timer=7) -> immediate IDLE with fail_cnt=0 and all outputs at reset values; next request accepted normally.
- With LOGIN_AUDIT_COUNTERS_EN: 5 grants and 2 denials -> grant_count=5 and deny_count=2. Without the macro, the same stimulus gives both counters 0.
